screen_compositor: RTL

Parametrised successor to the fixed three-screen LED compositor. It selects one of `N_SCREENS` per-screen RGB layers for the LED being rendered. On a screen change it cross-fades from the previous screen to the new one over `2^FADE_LOG2` frames. The block sits between the per-screen renderers (menu, gameplay, end, …) and the LED strip driver, and runs a 2-stage registered pixel pipeline with a valid qualifier.

---
 rtl/screen_compositor.sv | 127 ++++++++++++
 1 files changed

// File: rtl/screen_compositor.sv
// Per-LED screen compositor: picks the active screen layer and cross-fades from the
// previous screen over 2^FADE_LOG2 frames, through a 2-stage registered pixel pipeline.
module screen_compositor #(
  parameter int MAX_POS   = 109,
  parameter int N_SCREENS = 3,
  parameter int FADE_LOG2 = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   current_screen,
  input  logic                         frame_start,
  input  logic                         pix_valid,
  input  logic [$clog2(MAX_POS)-1:0]   pix_led,
  input  logic [N_SCREENS*24-1:0]      layer_rgb,
  output logic                         out_valid,
  output logic [$clog2(MAX_POS)-1:0]   out_led,
  output logic [7:0]                   led_green_intensity,
  output logic [7:0]                   led_red_intensity,
  output logic [7:0]                   led_blue_intensity,
  output logic                         fading
);

  localparam int LW = $clog2(MAX_POS);
  localparam int K  = 1 << FADE_LOG2;
  localparam int WW = (FADE_LOG2 > 0) ? FADE_LOG2 : 1;
  localparam int AW = FADE_LOG2 + 9;
  localparam logic [WW-1:0] LAST_STEP = WW'(K - 1);
  localparam logic [2:0]    NS        = 3'(N_SCREENS);

  // Weighted mix of new and old channel, truncated; the sum never exceeds 255*K.
  function automatic logic [7:0] blend(input logic [7:0]    nw,
                                       input logic [7:0]    od,
                                       input logic [WW-1:0] w);
    logic [AW-1:0] wn, wo, acc;
    wn  = AW'(w);
    wo  = AW'(K) - wn;
    acc = AW'(nw) * wn + AW'(od) * wo;
    return 8'(acc >> FADE_LOG2);
  endfunction

  logic [1:0]    r_active, r_prev;
  logic [WW-1:0] r_fade_step;
  logic          r_fading;
  logic          w_change;
  logic [23:0]   w_new, w_old;

  assign w_change = ({1'b0, current_screen} < NS) && (current_screen != r_active);
  assign w_new    = layer_rgb[int'(r_active)*24 +: 24];
  // Outside a fade the old operand is the new layer too, so the blend is exact.
  assign w_old    = r_fading ? layer_rgb[int'(r_prev)*24 +: 24] : w_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active    <= '0;
      r_prev      <= '0;
      r_fade_step <= '0;
      r_fading    <= 1'b0;
    end else if (frame_start) begin
      if (w_change) begin
        r_prev   <= r_active;
        r_active <= current_screen;
        if (K > 1) begin
          r_fade_step <= WW'(1);
          r_fading    <= 1'b1;
        end
      end else if (r_fading) begin
        if (r_fade_step == LAST_STEP) begin
          r_fading    <= 1'b0;
          r_fade_step <= '0;
        end else begin
          r_fade_step <= r_fade_step + WW'(1);
        end
      end
    end
  end

  // Stage 1: layer select, weight and LED index capture
  logic [23:0]   r_new_p1, r_old_p1;
  logic [WW-1:0] r_w_p1;
  logic [LW-1:0] r_led_p1;
  logic          r_vld_p1;

  always_ff @(posedge clk) begin
    if (pix_valid) begin
      r_new_p1 <= w_new;
      r_old_p1 <= w_old;
      r_w_p1   <= r_fade_step;
      r_led_p1 <= pix_led;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_p1 <= 1'b0;
    else        r_vld_p1 <= pix_valid;
  end

  // Stage 2: blended channels to the strip driver
  logic          r_vld_p2;
  logic [LW-1:0] r_led_p2;
  logic [7:0]    r_g_p2, r_r_p2, r_b_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2 <= 1'b0;
      r_led_p2 <= '0;
      r_g_p2   <= '0;
      r_r_p2   <= '0;
      r_b_p2   <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_led_p2 <= r_led_p1;
        r_g_p2   <= blend(r_new_p1[23:16], r_old_p1[23:16], r_w_p1);
        r_r_p2   <= blend(r_new_p1[15:8],  r_old_p1[15:8],  r_w_p1);
        r_b_p2   <= blend(r_new_p1[7:0],   r_old_p1[7:0],   r_w_p1);
      end
    end
  end

  assign out_valid           = r_vld_p2;
  assign out_led             = r_led_p2;
  assign led_green_intensity = r_g_p2;
  assign led_red_intensity   = r_r_p2;
  assign led_blue_intensity  = r_b_p2;
  assign fading              = r_fading;

endmodule
